// File: rtl/instr_encode_if.sv
// Request/result bus of the instruction encoder.
//   Request: in_valid, in_ready, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm
//   Result:  out_valid, out_ready, out_instr, out_err
// The master modport is the producer/consumer side; the slave modport is the encoder.
interface instr_encode_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/instr_encode.sv
// RV32I instruction encoder: checks that the immediate fits the format and
// packs fields into a 32-bit word. Unencodable requests yield NOP_WORD + out_err.
// One-deep valid/ready stage with saturating accept/error counters.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   bus         - request/result handshake (instr_encode_if.slave)
//   enc_count   - accepted requests (saturating)
//   err_count   - accepted erroneous requests (saturating)
module instr_encode #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    instr_encode_if.slave    bus,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int unsigned INSTR_W = 32;

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;
    localparam logic [2:0] FMT_R = 3'b101;

    logic [INSTR_W-1:0] word_c;
    logic               err_c;
    logic [INSTR_W-1:0] packed_c;
    logic               accept_c;
    logic               drain_c;
    logic [31:0]        imm;

    assign imm          = bus.imm;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept_c     = bus.in_valid && bus.in_ready;
    assign drain_c      = bus.out_valid && bus.out_ready;

    // Range check and field packing per format
    always_comb begin
        err_c    = 1'b0;
        packed_c = NOP_WORD;
        unique case (bus.fmt)
            FMT_I: begin
                err_c    = !((&imm[31:11]) || !(|imm[31:11]));
                packed_c = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            end
            FMT_S: begin
                err_c    = !((&imm[31:11]) || !(|imm[31:11]));
                packed_c = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
            end
            FMT_B: begin
                err_c    = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
                packed_c = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                            imm[4:1], imm[11], bus.opcode};
            end
            FMT_J: begin
                err_c    = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
                packed_c = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
            end
            FMT_U: begin
                err_c    = |imm[11:0];
                packed_c = {imm[31:12], bus.rd, bus.opcode};
            end
            FMT_R: begin
                packed_c = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            end
            default: begin
                err_c = 1'b1;
            end
        endcase
        word_c = err_c ? NOP_WORD : packed_c;
    end

    // Output register: accept reloads (even while draining), drain alone empties
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_instr <= '0;
            bus.out_err   <= 1'b0;
        end else if (accept_c) begin
            bus.out_valid <= 1'b1;
            bus.out_instr <= word_c;
            bus.out_err   <= err_c;
        end else if (drain_c) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Saturating statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (accept_c) begin
            if (enc_count != '1) enc_count <= enc_count + CNT_W'(1);
            if (err_c && (err_count != '1)) err_count <= err_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_instr_encode.sv
// Randomized + directed bench for instr_encode against a range/arithmetic model.
module tb_instr_encode;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_encode_if m ();
    instr_encode_if s ();
    logic [15:0] enc_count, err_count;
    logic [3:0]  s_enc, s_err;

    instr_encode #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(m.slave),
        .enc_count(enc_count), .err_count(err_count)
    );

    instr_encode #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .bus(s.slave),
        .enc_count(s_enc), .err_count(s_err)
    );

    typedef struct {
        logic [31:0] word;
        logic        err;
        logic [2:0]  fmt;
        logic [31:0] imm;
    } exp_t;

    exp_t        q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned enc_exp = 0;
    int unsigned err_exp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Encoding by signed range and arithmetic bit placement
    function automatic exp_t model(input logic [2:0] f, input logic [31:0] op, input logic [31:0] rd,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] f3, input logic [31:0] f7,
                                   input logic [31:0] u);
        exp_t e;
        longint v;
        logic ok;
        logic [31:0] w;
        v  = longint'($signed(u));
        ok = 1'b0;
        w  = 32'h0;
        case (f)
            3'd0: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = ((u & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
            end
            3'd1: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = (((u >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                   | ((u & 32'h1F) << 7) | op;
            end
            3'd2: begin
                ok = (v >= -4096) && (v <= 4095) && (v % 2 == 0);
                w  = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (r2 << 20)
                   | (r1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
                   | (((u >> 11) & 32'h1) << 7) | op;
            end
            3'd3: begin
                ok = (v >= -1048576) && (v <= 1048575) && (v % 2 == 0);
                w  = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                   | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | op;
            end
            3'd4: begin
                ok = (u % 4096) == 0;
                w  = (u & 32'hFFFFF000) | (rd << 7) | op;
            end
            3'd5: begin
                ok = 1'b1;
                w  = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
            end
            default: ok = 1'b0;
        endcase
        e.word = ok ? w : 32'h0000_0013;
        e.err  = !ok;
        e.fmt  = f;
        e.imm  = u;
        return e;
    endfunction

    // Immediate as the datapath extender would recover it
    function automatic logic [31:0] decode_imm(input logic [2:0] f, input logic [31:0] w);
        logic [31:0] sx;
        sx = 32'($signed(w) >>> 31);
        case (f)
            3'd0: return 32'($signed(w) >>> 20);
            3'd1: return (32'($signed(w) >>> 25) << 5) | ((w >> 7) & 32'h1F);
            3'd2: return (sx << 12) | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3F) << 5)
                       | (((w >> 8) & 32'hF) << 1);
            3'd3: return (sx << 20) | (((w >> 12) & 32'hFF) << 12) | (((w >> 20) & 32'h1) << 11)
                       | (((w >> 21) & 32'h3FF) << 1);
            default: return w & 32'hFFFFF000;
        endcase
    endfunction

    // One clock of the main DUT with scoreboard bookkeeping
    task automatic cycle_main();
        logic exp_valid, exp_ready, acc, drn;
        exp_t e;
        @(negedge clk);
        exp_valid = (q.size() != 0);
        exp_ready = !exp_valid || m.out_ready;
        check("out_valid", 32'(m.out_valid), 32'(exp_valid));
        check("in_ready", 32'(m.in_ready), 32'(exp_ready));
        if (exp_valid) begin
            check("out_instr", m.out_instr, q[0].word);
            check("out_err", 32'(m.out_err), 32'(q[0].err));
        end
        acc = m.in_valid && exp_ready;
        drn = exp_valid && m.out_ready;
        if (reset) begin
            q.delete();
            enc_exp = 0;
            err_exp = 0;
        end else begin
            if (drn) begin
                if (!q[0].err && q[0].fmt <= 3'd4)
                    check("roundtrip", decode_imm(q[0].fmt, m.out_instr), q[0].imm);
                void'(q.pop_front());
            end
            if (acc) begin
                e = model(m.fmt, 32'(m.opcode), 32'(m.rd), 32'(m.rs1), 32'(m.rs2),
                          32'(m.funct3), 32'(m.funct7), m.imm);
                q.push_back(e);
                if (enc_exp < 65535) enc_exp++;
                if (e.err && err_exp < 65535) err_exp++;
            end
        end
        @(posedge clk);
        #1;
        check("enc_count", 32'(enc_count), enc_exp);
        check("err_count", 32'(err_count), err_exp);
    endtask

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] im);
        m.fmt = f; m.opcode = op; m.rd = rd; m.rs1 = r1; m.rs2 = r2;
        m.funct3 = f3; m.funct7 = f7; m.imm = im;
    endtask

    task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
        set_req(f, op, rd, r1, r2, f3, f7, im);
        m.in_valid  = 1'b1;
        m.out_ready = 1'b1;
        cycle_main();
        m.in_valid = 1'b0;
    endtask

    task automatic rand_req();
        logic [31:0] im;
        case ($urandom_range(0, 4))
            0: im = $urandom;
            1: im = 32'($signed(12'($urandom)));
            2: im = 32'($signed(13'($urandom))) & 32'hFFFFFFFE;
            3: im = 32'($signed(21'($urandom))) & ~32'($urandom_range(0, 1));
            default: im = $urandom & 32'hFFFFF000;
        endcase
        set_req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), 3'($urandom), 7'($urandom), im);
    endtask

    initial begin
        reset = 1'b1;
        set_req(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        m.in_valid = 1'b0; m.out_ready = 1'b0;
        s.in_valid = 1'b0; s.out_ready = 1'b1; s.fmt = 3'd7; s.opcode = 7'h0;
        s.rd = '0; s.rs1 = '0; s.rs2 = '0; s.funct3 = '0; s.funct7 = '0; s.imm = '0;
        cycle_main();
        cycle_main();
        reset = 1'b0;
        check("rst_valid", 32'(m.out_valid), 32'd0);
        check("rst_instr", m.out_instr, 32'd0);
        check("rst_err", 32'(m.out_err), 32'd0);
        check("rst_enc", 32'(enc_count), 32'd0);

        req(3'd0, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        check("addi", m.out_instr, 32'hFFF00293);
        check("addi_enc", 32'(enc_count), 32'd1);
        req(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        check("beq", m.out_instr, 32'h00208463);
        req(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd9);
        check("beq_odd", m.out_instr, 32'h00000013);
        check("beq_odd_err", 32'(m.out_err), 32'd1);
        check("beq_odd_cnt", 32'(err_count), 32'd1);
        req(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        check("jal", m.out_instr, 32'h001000EF);
        req(3'd4, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        check("lui", m.out_instr, 32'h12345537);
        req(3'd4, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
        check("lui_bad", 32'(m.out_err), 32'd1);
        req(3'd0, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h7FF);
        check("i_max", m.out_instr, 32'h7FF00293);
        req(3'd0, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800);
        check("i_min", m.out_instr, 32'h80000293);
        req(3'd0, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        check("i_over", m.out_instr, 32'h00000013);
        check("i_over_err", 32'(m.out_err), 32'd1);

        // Backpressure: held result, new request waiting
        m.out_ready = 1'b0;
        rand_req();
        m.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle_main();
            check("bp_in_ready", 32'(m.in_ready), 32'd0);
        end
        m.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_req();
            cycle_main();
        end

        // Reset while holding a result and offered a new request
        m.out_ready = 1'b0;
        cycle_main();
        reset = 1'b1;
        cycle_main();
        reset = 1'b0;
        check("rst_hold_valid", 32'(m.out_valid), 32'd0);
        check("rst_hold_enc", 32'(enc_count), 32'd0);
        check("rst_hold_err", 32'(err_count), 32'd0);

        for (int i = 0; i < 400; i++) begin
            rand_req();
            m.in_valid  = 1'($urandom_range(0, 3) != 0);
            m.out_ready = 1'($urandom_range(0, 3) != 0);
            cycle_main();
        end
        m.in_valid  = 1'b0;
        m.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle_main();

        // Saturation on the narrow-counter instance
        s.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 9) check("sat_mid", 32'(s_enc), 32'd10);
        end
        s.in_valid = 1'b0;
        check("sat_enc", 32'(s_enc), 32'd15);
        check("sat_err", 32'(s_err), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_encode.md
Name: instr_encode

Overview:
Instruction encoder: the inverse of the datapath's immediate extender. It takes a format code, register/function fields and a 32-bit immediate, checks that the immediate is encodable, and packs everything into a 32-bit RV32I instruction word. It sits between the test/program generator and instruction-memory preload, and drives the processor's sign-extension check.
It is a one-deep valid/ready pipeline stage with error flagging and saturating statistics counters.

Parameters:
CNT_W, 16, width of the enc_count and err_count statistics counters
NOP_WORD, 32'h00000013, word emitted in place of any unencodable instruction (addi x0,x0,0)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  request carries a valid instruction description
in_ready  output  1  stage can accept a request this cycle
fmt  input  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 R; 110/111 illegal
opcode  input  7  instr[6:0]
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  instr[14:12]
funct7  input  7  instr[31:25]; R-type only
imm  input  32  full-width immediate, i.e. the value the extender must reproduce
out_valid  output  1  out_instr/out_err hold a result
out_ready  input  1  consumer accepts the result this cycle
out_instr  output  32  packed instruction word
out_err  output  1  request was unencodable; out_instr = NOP_WORD
enc_count  output  CNT_W  number of accepted requests, saturating
err_count  output  CNT_W  number of accepted erroneous requests, saturating

Behaviour:
- Reset, synchronous: out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0. Reset overrides every other event in the same cycle. A result held at reset is dropped.
- in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Accept happens when in_valid && in_ready. The result is registered, so out_valid=1 on the next edge: latency 1 cycle, full throughput.
- Output drain happens when out_valid && out_ready. Drain and accept may occur in the same cycle: the register reloads and out_valid stays 1.
- If out_valid=1 and out_ready=0, then out_instr, out_err and out_valid hold stable.
- Encodability checks (err=1 if the check fails):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm is ignored and the request is always legal.
  - fmt 110/111: always an error.
- Packing, in {high..low} order, opcode always in [6:0]:
  - I: {imm[11:0], rs1, funct3, rd}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0]}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11]}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd}
  - U: {imm[31:12], rd}
  - R: {funct7, rs2, rs1, funct3, rd}
- Field inputs that a format does not use are ignored.
- On error: out_instr=NOP_WORD, out_err=1.
- Invariant: for every non-error I/S/B/J/U result, sign-extending the immediate back out of out_instr yields exactly imm.
- Counters:
  - enc_count increments by 1 on every accept.
  - err_count increments by 1 on every accept that has err=1.
  - Both saturate at all-ones and never wrap.

Test Plan:
- I addi: fmt=000, opcode=0x13, rd=5, rs1=0, funct3=0, imm=0xFFFFFFFF -> next cycle out_valid=1, out_instr=0xFFF00293, out_err=0, enc_count=1.
- B beq: fmt=010, opcode=0x63, rs1=1, rs2=2, funct3=0, imm=8 -> out_instr=0x00208463. Repeat with imm=9 -> out_err=1, out_instr=0x00000013, err_count=1.
- J/U: jal with rd=1, opcode=0x6F, imm=0x800 -> 0x001000EF. lui with rd=10, opcode=0x37, imm=0x12345000 -> 0x12345537. lui with imm=0x12345001 -> err.
- I range boundary: imm=0x7FF and imm=0xFFFFF800 -> legal. imm=0x800 -> err, NOP_WORD.
- Backpressure: out_ready=0 for 5 cycles after one accept -> in_ready=0, out_instr stable, enc_count unchanged. Then out_ready=1 with in_valid=1 on back-to-back requests -> one result per cycle, none lost or duplicated.
- Reset and saturation:
  - Assert reset while out_valid=1 and in_valid=1 -> next cycle out_valid=0, counters=0.
  - With CNT_W=4, issue 20 accepts -> enc_count stays at 15.
